// File: rtl/cmu_pkg.sv
// Shared types and address helpers for the cache management unit.
// Optional miss counter is enabled with CMU_MISS_COUNT_EN.
package cmu_pkg;
    localparam int ADDR_W         = 30;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = 256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        DFILL   = 3'd2,
        IFILL   = 3'd3,
        RELEASE = 3'd4
    } cmu_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] idx;
        logic [2:0]        off;
    } addr_split_t;

    // Fields are returned full width; callers keep the low bits they need.
    function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] a,
                                               input int unsigned iw);
        addr_split_t r;
        r.off = a[2:0];
        r.idx = (a >> 3) & ((ADDR_W'(1) << iw) - ADDR_W'(1));
        r.tag = a >> (iw + 3);
        return r;
    endfunction
endpackage

// File: rtl/cache_mgmt_unit_if.sv
// Block-wide RAM port between the caches and the DDR controller.
// master = cache side, slave = DDR controller side.
interface cache_mgmt_unit_if;
    import cmu_pkg::*;

    logic              ram_en_out;
    logic              ram_write_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic [LINE_W-1:0] dc_data_wb;
    logic              ram_ready;
    logic [LINE_W-1:0] block_from_ram;

    modport master (
        output ram_en_out, ram_write_out, ram_addr_out, dc_data_wb,
        input  ram_ready, block_from_ram
    );

    modport slave (
        input  ram_en_out, ram_write_out, ram_addr_out, dc_data_wb,
        output ram_ready, block_from_ram
    );
endinterface

// File: rtl/cmu_cache_array.sv
// Direct-mapped line store: tag/valid/dirty/data with async read,
// byte-enabled word write and whole-line fill.
module cmu_cache_array
    import cmu_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx_i,
    input  logic [ADDR_W-INDEX_W-4:0] tag_i,
    input  logic [2:0]         off_i,
    input  logic               wr_en_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    input  logic               fill_i,
    input  logic [LINE_W-1:0]  fill_line_i,
    input  logic               clr_dirty_i,
    output logic               hit_o,
    output logic [31:0]        word_o,
    output logic               dirty_o,
    output logic [ADDR_W-INDEX_W-4:0] vtag_o,
    output logic [LINE_W-1:0]  line_o
);
    localparam int TAG_W = ADDR_W - INDEX_W - 3;
    localparam int NL    = 1 << INDEX_W;

    logic [NL-1:0]     valid_q, valid_d;
    logic [NL-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [NL];
    logic [LINE_W-1:0] data_q [NL];

    assign line_o  = data_q[idx_i];
    assign vtag_o  = tag_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign word_o  = line_o[{off_i, 5'd0} +: 32];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (wr_en_i) begin
            dirty_d[idx_i] = 1'b1;
        end else if (clr_dirty_i) begin
            dirty_d[idx_i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tags survive reset; only the valid bits gate them.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            data_q[idx_i] <= fill_line_i;
            tag_q[idx_i]  <= tag_i;
        end else if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b])
                    data_q[idx_i][{off_i, b[1:0], 3'b000} +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/cache_mgmt_unit.sv
// I-cache + write-back D-cache sharing one RAM port; stalls on any miss.
// Define CMU_MISS_COUNT_EN to add the miss_count output.
module cache_mgmt_unit
    import cmu_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read_in,
    input  logic              dc_read_in,
    input  logic              dc_write_in,
    input  logic [3:0]        dc_byte_w_en_in,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       data_from_reg,
    cache_mgmt_unit_if.master ram_if,
    output logic              mem_stall,
    output logic [31:0]       dc_data_out,
    output logic [31:0]       ic_data_out,
    output logic [2:0]        status,
    output logic [2:0]        counter
`ifdef CMU_MISS_COUNT_EN
    ,
    output logic [6:0]        miss_count
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - 3;

    addr_split_t ic_s, dc_s;
    logic [INDEX_W-1:0] ic_idx, dc_idx;
    logic [TAG_W-1:0]   ic_tag, dc_tag, dc_vtag, ic_vtag;
    logic [LINE_W-1:0]  dc_line, ic_line;
    logic ic_hit, dc_hit, dc_dirty, ic_dirty;
    logic ic_miss, dc_miss, dc_we;
    logic dc_fill, ic_fill, dc_clr;
    logic unused_bits;

    cmu_state_e state_q, state_d, ret_q, ret_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              en_q, en_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wb_q, wb_d;

    assign ic_s   = split_addr(ic_addr, INDEX_W);
    assign dc_s   = split_addr(dc_addr, INDEX_W);
    assign ic_idx = ic_s.idx[INDEX_W-1:0];
    assign dc_idx = dc_s.idx[INDEX_W-1:0];
    assign ic_tag = ic_s.tag[TAG_W-1:0];
    assign dc_tag = dc_s.tag[TAG_W-1:0];
    assign unused_bits = ^{ic_s.idx[ADDR_W-1:INDEX_W], dc_s.idx[ADDR_W-1:INDEX_W],
                           ic_s.tag[ADDR_W-1:TAG_W], dc_s.tag[ADDR_W-1:TAG_W],
                           ic_dirty, ic_vtag, ic_line};

    cmu_cache_array #(.INDEX_W(INDEX_W)) u_icache (
        .clk(clk), .rst(rst), .idx_i(ic_idx), .tag_i(ic_tag), .off_i(ic_s.off),
        .wr_en_i(1'b0), .be_i(4'b0000), .wdata_i(32'd0),
        .fill_i(ic_fill), .fill_line_i(ram_if.block_from_ram), .clr_dirty_i(1'b0),
        .hit_o(ic_hit), .word_o(ic_data_out), .dirty_o(ic_dirty),
        .vtag_o(ic_vtag), .line_o(ic_line)
    );

    cmu_cache_array #(.INDEX_W(INDEX_W)) u_dcache (
        .clk(clk), .rst(rst), .idx_i(dc_idx), .tag_i(dc_tag), .off_i(dc_s.off),
        .wr_en_i(dc_we), .be_i(dc_byte_w_en_in), .wdata_i(data_from_reg),
        .fill_i(dc_fill), .fill_line_i(ram_if.block_from_ram), .clr_dirty_i(dc_clr),
        .hit_o(dc_hit), .word_o(dc_data_out), .dirty_o(dc_dirty),
        .vtag_o(dc_vtag), .line_o(dc_line)
    );

    assign ic_miss   = ic_read_in & ~ic_hit;
    assign dc_miss   = (dc_read_in | dc_write_in) & ~dc_hit;
    assign mem_stall = (state_q != IDLE) | ic_miss | dc_miss;
    assign dc_we     = dc_write_in & dc_hit & ~mem_stall;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        en_d    = en_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wb_d    = wb_q;
        dc_fill = 1'b0;
        ic_fill = 1'b0;
        dc_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dc_miss) begin
                    en_d = 1'b1;
                    if (dc_dirty) begin
                        state_d = WB;
                        wr_d    = 1'b1;
                        addr_d  = {dc_vtag, dc_idx, 3'b000};
                        wb_d    = dc_line;
                    end else begin
                        state_d = DFILL;
                        wr_d    = 1'b0;
                        addr_d  = {dc_addr[ADDR_W-1:3], 3'b000};
                    end
                end else if (ic_miss) begin
                    state_d = IFILL;
                    en_d    = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = {ic_addr[ADDR_W-1:3], 3'b000};
                end
            end
            WB: begin
                if (ram_if.ram_ready) begin
                    en_d    = 1'b0;
                    dc_clr  = 1'b1;
                    state_d = RELEASE;
                    ret_d   = DFILL;
                end
            end
            DFILL: begin
                if (ram_if.ram_ready) begin
                    en_d    = 1'b0;
                    dc_fill = 1'b1;
                    state_d = RELEASE;
                    ret_d   = IDLE;
                end
            end
            IFILL: begin
                if (ram_if.ram_ready) begin
                    en_d    = 1'b0;
                    ic_fill = 1'b1;
                    state_d = RELEASE;
                    ret_d   = IDLE;
                end
            end
            RELEASE: begin
                // Hold off until the controller drops ready before re-requesting.
                if (!ram_if.ram_ready) begin
                    state_d = ret_q;
                    if (ret_q == DFILL) begin
                        en_d   = 1'b1;
                        wr_d   = 1'b0;
                        addr_d = {dc_addr[ADDR_W-1:3], 3'b000};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && state_q != IDLE)
            cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
        end
    end

    assign status               = state_q;
    assign counter              = cnt_q;
    assign ram_if.ram_en_out    = en_q;
    assign ram_if.ram_write_out = wr_q;
    assign ram_if.ram_addr_out  = addr_q;
    assign ram_if.dc_data_wb    = wb_q;

`ifdef CMU_MISS_COUNT_EN
    logic [6:0] mc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mc_q <= '0;
        else if (state_q == IDLE && state_d != IDLE)
            mc_q <= mc_q + 7'd1;
    end

    assign miss_count = mc_q;
`endif
endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Randomised bench for cache_mgmt_unit against an architectural memory
// model plus a responder that emulates the DDR controller.
module tb_cache_mgmt_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_read_in, dc_read_in, dc_write_in;
    logic [3:0]  dc_byte_w_en_in;
    logic [29:0] ic_addr, dc_addr;
    logic [31:0] data_from_reg;
    logic        mem_stall;
    logic [31:0] dc_data_out, ic_data_out;
    logic [2:0]  status, counter;
`ifdef CMU_MISS_COUNT_EN
    logic [6:0]  miss_count;
`endif

    cache_mgmt_unit_if ram_if();

    cache_mgmt_unit dut (
        .clk(clk), .rst(rst),
        .ic_read_in(ic_read_in), .dc_read_in(dc_read_in),
        .dc_write_in(dc_write_in), .dc_byte_w_en_in(dc_byte_w_en_in),
        .ic_addr(ic_addr), .dc_addr(dc_addr), .data_from_reg(data_from_reg),
        .ram_if(ram_if),
        .mem_stall(mem_stall), .dc_data_out(dc_data_out),
        .ic_data_out(ic_data_out), .status(status), .counter(counter)
`ifdef CMU_MISS_COUNT_EN
        , .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: backing DDR contents, the CPU-visible memory, and which blocks
    // each cache holds.
    logic [31:0] ram_m  [logic [29:0]];
    logic [31:0] arch_m [logic [29:0]];
    bit          ic_v [64];
    bit          dc_v [64];
    bit          dc_d [64];
    logic [20:0] ic_t [64];
    logic [20:0] dc_t [64];

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        int          st;
    } req_t;
    req_t expq[$];

    function automatic logic [31:0] ram_rd(input logic [29:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic logic [31:0] arch_rd(input logic [29:0] a);
        if (arch_m.exists(a)) return arch_m[a];
        return ram_rd(a);
    endfunction

    function automatic logic [255:0] blk_of(input logic [29:0] base, input bit use_arch);
        logic [255:0] b;
        for (int w = 0; w < 8; w++)
            b[32*w +: 32] = use_arch ? arch_rd(base + 30'(w)) : ram_rd(base + 30'(w));
        return b;
    endfunction

    task automatic predict(input bit icr, input logic [29:0] ia,
                           input bit dacc, input logic [29:0] da);
        logic [5:0] i;
        expq.delete();
        if (dacc) begin
            i = da[8:3];
            if (!(dc_v[i] && dc_t[i] == da[29:9])) begin
                if (dc_d[i]) expq.push_back('{1'b1, {dc_t[i], i, 3'b000}, 1});
                expq.push_back('{1'b0, {da[29:3], 3'b000}, 2});
                dc_v[i] = 1'b1;
                dc_d[i] = 1'b0;
                dc_t[i] = da[29:9];
            end
        end
        if (icr) begin
            i = ia[8:3];
            if (!(ic_v[i] && ic_t[i] == ia[29:9])) begin
                expq.push_back('{1'b0, {ia[29:3], 3'b000}, 3});
                ic_v[i] = 1'b1;
                ic_t[i] = ia[29:9];
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            if (dc_d[i])
                for (int w = 0; w < 8; w++)
                    arch_m.delete({dc_t[i], 6'(i), 3'b000} + 30'(w));
            dc_v[i] = 1'b0;
            dc_d[i] = 1'b0;
            ic_v[i] = 1'b0;
        end
    endtask

    task automatic do_op(input bit icr, input logic [29:0] ia,
                         input bit dr, input bit dw, input logic [29:0] da,
                         input logic [3:0] be, input logic [31:0] wd,
                         output logic [31:0] dout);
        bit   pend;
        int   cyc, lat, waited, hold, rel_n;
        req_t r;
        logic [31:0] w;
        pend = 0; hold = 0; rel_n = 0; lat = 0; waited = 0; cyc = 0;
        r = '{1'b0, 30'd0, 0};
        dout = '0;
        @(negedge clk);
        ic_read_in = icr; ic_addr = ia;
        dc_read_in = dr; dc_write_in = dw; dc_addr = da;
        dc_byte_w_en_in = be; data_from_reg = wd;
        predict(icr, ia, dr | dw, da);
        #1;
        chk("stall0", 256'(mem_stall), 256'(expq.size() != 0));
        forever begin
            if (!mem_stall) begin
                if (dr) chk("dload", 256'(dc_data_out), 256'(arch_rd(da)));
                if (icr) chk("ifetch", 256'(ic_data_out), 256'(arch_rd(ia)));
                dout = dc_data_out;
                if (dw) begin
                    w = arch_rd(da);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                    arch_m[da] = w;
                    dc_d[da[8:3]] = 1'b1;
                end
                chk("qempty", 256'(expq.size()), 256'(0));
                break;
            end
            if (ram_if.ram_ready) begin
                chk("en_rel", 256'(ram_if.ram_en_out), 256'(0));
                chk("st_rel", 256'(status), 256'(4));
                chk("cnt_rel", 256'(counter), 256'(rel_n > 7 ? 7 : rel_n));
                rel_n++;
                hold--;
                if (hold == 0) ram_if.ram_ready = 1'b0;
            end else begin
                if (!pend && ram_if.ram_en_out) begin
                    if (expq.size() == 0) begin
                        chk("extra_req", 256'(ram_if.ram_addr_out), 256'(0));
                        r = '{ram_if.ram_write_out, ram_if.ram_addr_out, 0};
                    end else begin
                        r = expq.pop_front();
                        chk("ram_wr", 256'(ram_if.ram_write_out), 256'(r.wr));
                        chk("ram_addr", 256'(ram_if.ram_addr_out), 256'(r.addr));
                        chk("status", 256'(status), 256'(r.st));
                        if (r.wr) begin
                            chk("wb_data", ram_if.dc_data_wb, blk_of(r.addr, 1'b1));
                            for (int k = 0; k < 8; k++)
                                ram_m[r.addr + 30'(k)] = arch_rd(r.addr + 30'(k));
                        end
                    end
                    pend = 1;
                    waited = 0;
                    lat = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 11)
                                                     : $urandom_range(0, 2);
                end
                if (pend) begin
                    if (lat == 0) begin
                        chk("cnt_wait", 256'(counter), 256'(waited > 7 ? 7 : waited));
                        chk("en_hold", 256'(ram_if.ram_en_out), 256'(1));
                        chk("addr_hold", 256'(ram_if.ram_addr_out), 256'(r.addr));
                        ram_if.block_from_ram = r.wr ? '0 : blk_of(r.addr, 1'b0);
                        ram_if.ram_ready = 1'b1;
                        hold = $urandom_range(1, 3);
                        rel_n = 0;
                        pend = 0;
                    end else begin
                        lat--;
                        waited++;
                    end
                end
            end
            cyc++;
            if (cyc > 300) begin
                chk("timeout", 256'(cyc), 256'(0));
                ram_if.ram_ready = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    logic [31:0] d;

    initial begin
        ic_read_in = 0; dc_read_in = 0; dc_write_in = 0;
        dc_byte_w_en_in = '0; ic_addr = '0; dc_addr = '0; data_from_reg = '0;
        ram_if.ram_ready = 1'b0;
        ram_if.block_from_ram = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_status", 256'(status), 256'(0));
        chk("rst_en", 256'(ram_if.ram_en_out), 256'(0));
        chk("rst_cnt", 256'(counter), 256'(0));
        chk("rst_addr", 256'(ram_if.ram_addr_out), 256'(0));
        chk("rst_stall", 256'(mem_stall), 256'(0));
        rst = 1'b0;

        ram_m[30'h100] = 32'hDEADBEEF;
        do_op(0, '0, 1, 0, 30'h100, 4'h0, '0, d);
        chk("t1_word0", 256'(d), 256'(32'hDEADBEEF));

        do_op(0, '0, 0, 1, 30'h100, 4'hF, 32'h11223344, d);
        do_op(0, '0, 0, 1, 30'h100, 4'h1, 32'h000000AA, d);
        do_op(0, '0, 1, 0, 30'h100, 4'h0, '0, d);
        chk("t2_merge", 256'(d), 256'(32'h112233AA));

        do_op(0, '0, 1, 0, 30'h300, 4'h0, '0, d);
        do_op(1, 30'h2000_0010, 1, 0, 30'h510, 4'h0, '0, d);

        @(negedge clk);
        ic_read_in = 0; dc_write_in = 0;
        dc_read_in = 1; dc_addr = 30'h408;
        for (int k = 0; k < 20 && !ram_if.ram_en_out; k++) @(negedge clk);
        #1;
        chk("t5_req", 256'(ram_if.ram_en_out), 256'(1));
        rst = 1'b1;
        #1;
        chk("t5_en", 256'(ram_if.ram_en_out), 256'(0));
        chk("t5_status", 256'(status), 256'(0));
        chk("t5_cnt", 256'(counter), 256'(0));
        chk("t5_addr", 256'(ram_if.ram_addr_out), 256'(0));
        chk("t5_wb", ram_if.dc_data_wb, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        dc_read_in = 0;
        model_reset();
        do_op(0, '0, 1, 0, 30'h100, 4'h0, '0, d);

        for (int n = 0; n < 300; n++) begin
            logic [29:0] ia, da;
            int kind;
            ia = {1'b1, 18'd0, 2'($urandom_range(0, 3)), 3'd0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            da = {19'd0, 2'($urandom_range(0, 3)), 3'd0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            kind = $urandom_range(0, 2);
            do_op(1'($urandom_range(0, 1)), ia, kind == 1, kind == 2, da,
                  4'($urandom_range(1, 15)), $urandom, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mgmt_unit.md
Name: cache_mgmt_unit

Overview:
Direct-mapped instruction cache and write-back, write-allocate data cache sharing one block-wide RAM port to the DDR controller. Sits between the pipeline fetch/memory stages and the DDR controller. Stalls the pipeline on any miss. Serialises line write-backs and fills over a 256-bit request/ready handshake.

Parameters:
INDEX_W, 6, index bits per cache; 2**INDEX_W lines each, 8 words (256 bits) per line.
ADDR_W, 30, word-address width.

Ports:
clk  in  1  single clock; all state on posedge.
rst  in  1  reset, asynchronous, active-high.
ic_read_in  in  1  instruction fetch request.
dc_read_in  in  1  data load request.
dc_write_in  in  1  data store request.
dc_byte_w_en_in  in  4  store byte enables; bit i writes word bits [8i+7:8i].
ic_addr  in  30  fetch word address.
dc_addr  in  30  data word address.
data_from_reg  in  32  store data, already lane-aligned.
ram_ready  in  1  RAM transaction done; block_from_ram valid while high.
block_from_ram  in  256  fill block; word w at bits [32w+31:32w].
mem_stall  out  1  pipeline stall, combinational.
dc_data_out  out  32  load data, combinational on hit.
ic_data_out  out  32  fetched instruction, combinational on hit.
status  out  3  FSM state code (debug).
counter  out  3  wait-cycle counter (debug).
ram_en_out  out  1  RAM request.
ram_write_out  out  1  1 = write-back, 0 = fill.
ram_addr_out  out  30  block-aligned word address, low 3 bits = 0.
dc_data_wb  out  256  victim line for write-back.

Behaviour:
- Address split: word offset = addr[2:0]; index = addr[INDEX_W+2:3]; tag = addr[29:INDEX_W+3].
- Hit: line valid and tag equal.
  - ic_miss = ic_read_in & !ic_hit.
  - dc_miss = (dc_read_in | dc_write_in) & !dc_hit.
- mem_stall = (state != IDLE) | ic_miss | dc_miss.
- dc_data_out / ic_data_out: addressed word of the indexed line; don't-care on miss.
- CPU store commits at posedge only when dc_write_in & dc_hit & !mem_stall. It writes the enabled bytes and sets the line dirty.
- FSM states and status codes: IDLE=0, WB=1, DFILL=2, IFILL=3, RELEASE=4.
- IDLE transitions, D side has priority when both miss in the same cycle:
  - dc_miss with dirty victim -> WB.
  - dc_miss with clean victim -> DFILL.
  - else ic_miss -> IFILL.
- WB:
  - Outputs: ram_en_out=1, ram_write_out=1, ram_addr_out={victim tag, index, 000}, dc_data_wb=victim line.
  - On ram_ready: clear dirty, go to RELEASE, then DFILL.
- DFILL:
  - Outputs: ram_en_out=1, ram_write_out=0, ram_addr_out={dc_addr[29:3], 000}.
  - On ram_ready: write block_from_ram into the line, set valid, clear dirty, go to RELEASE, then IDLE.
- IFILL: same as DFILL using ic_addr and the I-cache.
- RELEASE: ram_en_out=0; wait until ram_ready=0, then go to the next state. A new request is never issued while ram_ready is still high.
- Request hold: ram_en_out, ram_write_out, ram_addr_out and dc_data_wb stay stable from request until the ram_ready cycle. ram_en_out is registered and drops the cycle after ram_ready is seen.
- Write miss: after the fill, returns to IDLE. The store then hits and commits on the first unstalled cycle.
- counter: cycles spent in the current non-IDLE state, saturating at 7. Cleared on every state change and held 0 in IDLE.
- Reset (also mid-transaction):
  - Immediately: state=IDLE, ram_en_out=0, ram_write_out=0, counter=0, all valid and dirty bits cleared.
  - Data arrays are not cleared.
  - ram_addr_out=0 and dc_data_wb=0.

Optional Feature:
CMU_MISS_COUNT_EN:
- Defined: adds output miss_count[6:0]. It increments (wrapping) on each IDLE -> WB/DFILL/IFILL transition and is cleared by rst.
- Undefined: port and logic are absent.

Decomposition:
- Package cmu_pkg holds:
  - state codes IDLE..RELEASE.
  - constants WORDS_PER_LINE=8, LINE_W=256, ADDR_W=30.
  - a function that extracts tag/index/offset.
- Sub-module cmu_cache_array, instantiated twice (I and D). It provides:
  - tag/valid/dirty/data storage with async read.
  - byte-enabled word write and full-line fill write.

Test Plan:
1. rst pulse, then dc_read_in at 0x100 -> mem_stall=1; DFILL with ram_addr_out=0x100, ram_write_out=0; ram_ready with block word0=0xDEADBEEF -> after RELEASE, dc_data_out=0xDEADBEEF, mem_stall=0.
2. Store 0x11223344 with byte-en 4'b1111 to a cached 0x100, then byte-en 4'b0001 with data 0x000000AA -> load returns 0x112233AA, no stall.
3. Dirty 0x100, then load 0x100+(8<<INDEX_W) -> WB with ram_addr_out=0x100 and dc_data_wb word0=0x112233AA; then DFILL at the new address.
4. Simultaneous ic and dc miss -> DFILL issued before IFILL; ram_en_out low during RELEASE until ram_ready=0.
5. Assert rst during DFILL before ram_ready -> ram_en_out=0, status=0, previous hit at 0x100 now misses.
6. Hold ram_ready high 3 cycles after fill -> no new request until it drops; counter saturates at 7 under a long wait.
